stb_fwd_buffer: RTL
===================

# stb_fwd_buffer

Second-generation store buffer between the LSU data-bus port and the dcache. It accepts stores into a parametrised FIFO and drains them to the dcache in order over a req/ack handshake. It answers LSU load lookups with per-byte forwarded data from pending stores. Optionally, it coalesces a store into the youngest entry when the word address matches.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; multiple of 8
- BYTE_SEL_WIDTH, DATA_WIDTH/8, byte-enable width
- FIFO_DEPTH, 8, number of entries; power of two, at least 2

Ports:
- clk, in, 1, clock; all logic on rising edge
- rst, in, 1, reset; asynchronous, active-high
- lsudbus2stb_req, in, 1, store request
- lsudbus2stb_addr, in, ADDR_WIDTH, store address
- lsudbus2stb_wdata, in, DATA_WIDTH, store data
- lsudbus2stb_sel_byte, in, BYTE_SEL_WIDTH, store byte enables
- stb2dbuslsu_ack, out, 1, store accepted this cycle (combinational)
- stb2dbuslsu_stall, out, 1, lsudbus2stb_req & ~stb2dbuslsu_ack
- lsu2stb_ld_addr, in, ADDR_WIDTH, load lookup address
- stb2lsu_ld_hit, out, 1, any byte of the lookup word is pending
- stb2lsu_ld_data, out, DATA_WIDTH, forwarded bytes; 0 where not covered
- stb2lsu_ld_sel, out, BYTE_SEL_WIDTH, bytes supplied by the buffer
- stb_flush, in, 1, level; block new stores until empty
- stb2dcache_req, stb2dcache_w_en, dmem_sel_o, out, 1 each, drain request; all three are identical
- stb2dcache_addr, out, ADDR_WIDTH, drain address
- stb2dcache_wdata, out, DATA_WIDTH, drain data
- stb2dcache_sel_byte, out, BYTE_SEL_WIDTH, drain byte enables
- dcache2stb_ack, in, 1, dcache completed the current drain write
- stb2dcache_empty, out, 1, no valid entries
- stb_count, out, $clog2(FIFO_DEPTH+1), valid entry count

## Operation
- Circular FIFO with head and tail pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH. Full/empty are derived from count.
- Store acceptance: ack = req & ~stb_flush & (~full | coalesce_hit). On accept, an entry {addr, data, sel} is written at tail, or merged when coalescing.
- Drain FSM:
  - IDLE: moves to DRAIN when count != 0.
  - DRAIN: req=1, outputs carry the head entry and stay stable until ack.
  - On ack: head pops. The FSM stays in DRAIN if entries remain after the pop, otherwise it returns to IDLE.
  - ack while in IDLE is ignored.
- The entry being drained is locked: it is never coalesced into and never overwritten.
- Flush blocks acceptance only; draining proceeds normally. The buffer always drains when non-empty.
- Forwarding (combinational):
  - A word matches when the stored address equals lsu2stb_ld_addr with the low $clog2(BYTE_SEL_WIDTH) bits ignored.
  - For each byte, the youngest valid matching entry with that byte enabled supplies it.
  - The head entry is included until the cycle its ack pops it.
  - A store accepted in the same cycle as a lookup is not visible to that lookup.
- Simultaneous push and pop: count is unchanged. When full, a pop in the same cycle does not allow a push; the LSU waits a cycle.

## Timing
- Reset values: every output is 0 and stb2dcache_empty is 1. All entries are invalid and the FSM is in IDLE.
- Reset takes effect asynchronously mid-drain, so req drops without waiting for ack.
- A store accepted in cycle N is visible to lookups and stb_count from N+1.
- If the FSM was in IDLE, stb2dcache_req is high from N+1, carrying that entry.
- With ack in cycle M:
  - If count was greater than 1, or a push arrived in M: req stays high in M+1 with the next head.
  - Otherwise req is low in M+1.
  - Steady state is one drain per cycle under back-to-back acks.
- Lookup results reflect register state; there is zero-cycle latency from lsu2stb_ld_addr.

## Configuration
- STB_COALESCE_EN defined:
  - coalesce_hit is set when the buffer is non-empty, the youngest entry is not locked, and its word address equals the incoming word address.
  - The merge ORs the byte enables, overwrites the enabled data bytes, and leaves count unchanged.
  - A coalescing store is accepted even when the buffer is full.
- STB_COALESCE_EN undefined: coalesce_hit is tied to 0 and every accepted store allocates a new entry.

## Structure
- Package stb_pkg holds:
  - typedef stb_entry_t {addr, data, sel, valid}
  - drain FSM enum stb_state_e {STB_IDLE, STB_DRAIN}
  - helper constant for word-offset bits
- Sub-module stb_fwd_lookup: combinational per-byte youngest-match forwarding over the entry array and head/tail pointers.

## Test plan
- Reset, then store addr 0x100, data 0xAABBCCDD, sel 0xF. Expected: ack the same cycle; req and addr 0x100 the next cycle; ack held high 3 cycles; empty=1 after the pop.
- Fill 8 entries with no dcache ack, then a 9th store to a new word. Expected: stall=1 and count=8. One ack pops an entry; the store is accepted the following cycle; the 8 writes drain in FIFO order.
- Stores to 0x200 with sel 0x3 (data 0x....1122), then 0x200 with sel 0xC (data 0x3344....); then lookup 0x202. Expected: hit=1, ld_sel=0xF, ld_data=0x33441122. With STB_COALESCE_EN: count=1, unless the first store was already locked by the drain.
- Two stores to 0x300 (sel 0xF, data 0x11111111, then sel 0x1, data 0x22), with coalescing off. Expected: lookup returns 0x11111122.
- Hold stb_flush with 3 entries pending and a store request. Expected: stall held until empty after 3 acks; the store is accepted after flush drops.
- Assert rst mid-DRAIN. Expected: req, count and hit go to 0 immediately; a stray dcache ack after reset is ignored.

Source files
------------

// File: rtl/stb_pkg.sv
// Shared types for the store buffer: entry record, drain FSM states and word-offset helpers.
package stb_pkg;

  localparam int STB_ADDR_W   = 32;
  localparam int STB_DATA_W   = 32;
  localparam int STB_SEL_W    = STB_DATA_W / 8;
  localparam int STB_WORD_OFF = $clog2(STB_SEL_W);

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
    logic [STB_SEL_W-1:0]  sel;
    logic                  valid;
  } stb_entry_t;

  typedef enum logic {
    STB_IDLE  = 1'b0,
    STB_DRAIN = 1'b1
  } stb_state_e;

  function automatic logic same_word(input logic [STB_ADDR_W-1:0] a,
                                     input logic [STB_ADDR_W-1:0] b);
    return a[STB_ADDR_W-1:STB_WORD_OFF] == b[STB_ADDR_W-1:STB_WORD_OFF];
  endfunction

endpackage

// File: rtl/stb_fwd_lookup.sv
// Per-byte load forwarding: walks entries oldest to youngest from head so the youngest match wins.
module stb_fwd_lookup
  import stb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  stb_entry_t             entries [FIFO_DEPTH],
  input  logic [PTR_W-1:0]       head,
  input  logic [STB_ADDR_W-1:0]  ld_addr,
  output logic                   ld_hit,
  output logic [STB_DATA_W-1:0]  ld_data,
  output logic [STB_SEL_W-1:0]   ld_sel
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    ld_data = '0;
    ld_sel  = '0;
    idx     = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (entries[idx].valid && same_word(entries[idx].addr, ld_addr)) begin
        for (int b = 0; b < STB_SEL_W; b++) begin
          if (entries[idx].sel[b]) begin
            ld_sel[b]          = 1'b1;
            ld_data[8*b +: 8]  = entries[idx].data[8*b +: 8];
          end
        end
      end
    end
    ld_hit = |ld_sel;
  end

endmodule

// File: rtl/stb_fwd_buffer.sv
// Store buffer with in-order dcache drain and load forwarding.
// Define STB_COALESCE_EN to merge stores into the youngest unlocked entry of the same word.
module stb_fwd_buffer
  import stb_pkg::*;
#(
  parameter int ADDR_WIDTH     = STB_ADDR_W,
  parameter int DATA_WIDTH     = STB_DATA_W,
  parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              lsudbus2stb_req,
  input  logic [ADDR_WIDTH-1:0]             lsudbus2stb_addr,
  input  logic [DATA_WIDTH-1:0]             lsudbus2stb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0]         lsudbus2stb_sel_byte,
  output logic                              stb2dbuslsu_ack,
  output logic                              stb2dbuslsu_stall,
  input  logic [ADDR_WIDTH-1:0]             lsu2stb_ld_addr,
  output logic                              stb2lsu_ld_hit,
  output logic [DATA_WIDTH-1:0]             stb2lsu_ld_data,
  output logic [BYTE_SEL_WIDTH-1:0]         stb2lsu_ld_sel,
  input  logic                              stb_flush,
  output logic                              stb2dcache_req,
  output logic                              stb2dcache_w_en,
  output logic                              dmem_sel_o,
  output logic [ADDR_WIDTH-1:0]             stb2dcache_addr,
  output logic [DATA_WIDTH-1:0]             stb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0]         stb2dcache_sel_byte,
  input  logic                              dcache2stb_ack,
  output logic                              stb2dcache_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   stb_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]     ent_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     ent_data [FIFO_DEPTH];
  logic [BYTE_SEL_WIDTH-1:0] ent_sel  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     ent_vld;
  stb_entry_t                entries  [FIFO_DEPTH];

  logic [PTR_W-1:0] head, tail, yng;
  logic [CNT_W-1:0] count, count_next;
  stb_state_e       state;
  logic             full, coal_hit, accept, push_new, pop, drain_req;

  assign yng  = tail - PTR_W'(1);
  assign full = (count == CNT_W'(FIFO_DEPTH));

`ifdef STB_COALESCE_EN
  // With one entry pending it is the head and therefore locked by the drain.
  assign coal_hit = (count > CNT_W'(1)) &&
                    (ent_addr[yng][ADDR_WIDTH-1:STB_WORD_OFF] ==
                     lsudbus2stb_addr[ADDR_WIDTH-1:STB_WORD_OFF]);
`else
  assign coal_hit = 1'b0;
`endif

  assign accept     = lsudbus2stb_req & ~stb_flush & (~full | coal_hit);
  assign push_new   = accept & ~coal_hit;
  assign drain_req  = (state == STB_DRAIN);
  assign pop        = drain_req & dcache2stb_ack;
  assign count_next = count + CNT_W'(push_new) - CNT_W'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
      state   <= STB_IDLE;
    end else begin
      count <= count_next;
      if (push_new) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      case (state)
        STB_IDLE:  if (count_next != '0) state <= STB_DRAIN;
        STB_DRAIN: if (pop && count_next == '0) state <= STB_IDLE;
        default:   state <= STB_IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives in ent_vld.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (coal_hit) begin
        for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
          if (lsudbus2stb_sel_byte[b]) ent_data[yng][8*b +: 8] <= lsudbus2stb_wdata[8*b +: 8];
        end
        ent_sel[yng] <= ent_sel[yng] | lsudbus2stb_sel_byte;
      end else begin
        ent_addr[tail] <= lsudbus2stb_addr;
        ent_data[tail] <= lsudbus2stb_wdata;
        ent_sel[tail]  <= lsudbus2stb_sel_byte;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entries[i] = '{addr: ent_addr[i], data: ent_data[i], sel: ent_sel[i], valid: ent_vld[i]};
    end
  end

  stb_fwd_lookup #(.FIFO_DEPTH(FIFO_DEPTH)) u_lookup (
    .entries (entries),
    .head    (head),
    .ld_addr (lsu2stb_ld_addr),
    .ld_hit  (stb2lsu_ld_hit),
    .ld_data (stb2lsu_ld_data),
    .ld_sel  (stb2lsu_ld_sel)
  );

  assign stb2dbuslsu_ack     = accept;
  assign stb2dbuslsu_stall   = lsudbus2stb_req & ~accept;
  assign stb2dcache_req      = drain_req;
  assign stb2dcache_w_en     = drain_req;
  assign dmem_sel_o          = drain_req;
  assign stb2dcache_addr     = drain_req ? ent_addr[head] : '0;
  assign stb2dcache_wdata    = drain_req ? ent_data[head] : '0;
  assign stb2dcache_sel_byte = drain_req ? ent_sel[head]  : '0;
  assign stb2dcache_empty    = (count == '0);
  assign stb_count           = count;

endmodule
